kmap_sweep_ctrl: RTL

Sequencer that exhaustively exercises a 4-input combinational minimized function (the K-map lab blocks, ports a,b,c,d → f). On start it drives all 16 minterms in order, captures f for each, then compares the captured truth table against an expected ON-set with don't-care mask. It reports pass/fail, per-minterm mismatches and the first failing minterm. Sits between a lab stimulus/top wrapper and the function under test.

---
 rtl/kmap_sweep_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/kmap_sweep_ctrl.sv
// kmap_sweep_ctrl: drives all 16 minterms of a 4-input function under test,
// captures f for each, and scores the captured truth table against an
// expected ON-set with a don't-care mask.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | a..d = 0, waiting for start; results of last sweep held
// ST_SETTLE  | minterm m driven, waiting for f to settle (down-counter)
// ST_SAMPLE  | minterm m still driven, f captured into table bit m
// ST_COMPARE | mismatch / pass / first_err computed and registered
// ST_DONE    | last busy cycle; done pulses on the edge leaving this state
module kmap_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] exp_on,
    input  logic [15:0] dc_mask,
    input  logic        f,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] table_out,
    output logic [15:0] mismatch,
    output logic [3:0]  first_err,
    output logic        err_valid
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_COMPARE,
        ST_DONE
    } state_t;

    // Settle counter counts down to zero, so it is loaded with one less than
    // the number of settle cycles.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  m_q, m_d;
    logic [3:0]  settle_q, settle_d;
    logic [15:0] exp_q, exp_d;
    logic [15:0] dc_q, dc_d;
    logic [15:0] table_q, table_d;
    logic [15:0] mismatch_q, mismatch_d;
    logic [3:0]  first_err_q, first_err_d;
    logic        err_valid_q, err_valid_d;
    logic        pass_q, pass_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [15:0] mism_c;
    logic [3:0]  fe_c;
    logic        drive;

    // Unmasked mismatches and their lowest index (scan high to low so the
    // lowest set bit is the last one written).
    always_comb begin
        mism_c = (table_q ^ exp_q) & ~dc_q;
        fe_c   = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            if (mism_c[i]) begin
                fe_c = 4'(i);
            end
        end
    end

    // Next-state and result logic.
    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        settle_d    = settle_q;
        exp_d       = exp_q;
        dc_d        = dc_q;
        table_d     = table_q;
        mismatch_d  = mismatch_q;
        first_err_d = first_err_q;
        err_valid_d = err_valid_q;
        pass_d      = pass_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    exp_d       = exp_on;
                    dc_d        = dc_mask;
                    table_d     = 16'h0000;
                    mismatch_d  = 16'h0000;
                    first_err_d = 4'h0;
                    err_valid_d = 1'b0;
                    pass_d      = 1'b0;
                    m_d         = 4'h0;
                    settle_d    = SETTLE_LOAD;
                    busy_d      = 1'b1;
                    state_d     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == 4'h0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    settle_d = settle_q - 4'h1;
                end
            end
            ST_SAMPLE: begin
                table_d[m_q] = f;
                if (m_q == 4'hF) begin
                    state_d = ST_COMPARE;
                end else begin
                    m_d      = m_q + 4'h1;
                    settle_d = SETTLE_LOAD;
                    state_d  = ST_SETTLE;
                end
            end
            ST_COMPARE: begin
                mismatch_d  = mism_c;
                err_valid_d = |mism_c;
                pass_d      = ~(|mism_c);
                first_err_d = fe_c;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                m_d     = 4'h0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset discards any partial sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            m_q         <= 4'h0;
            settle_q    <= 4'h0;
            exp_q       <= 16'h0000;
            dc_q        <= 16'h0000;
            table_q     <= 16'h0000;
            mismatch_q  <= 16'h0000;
            first_err_q <= 4'h0;
            err_valid_q <= 1'b0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            settle_q    <= settle_d;
            exp_q       <= exp_d;
            dc_q        <= dc_d;
            table_q     <= table_d;
            mismatch_q  <= mismatch_d;
            first_err_q <= first_err_d;
            err_valid_q <= err_valid_d;
            pass_q      <= pass_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Minterm is only presented while settling or sampling.
    assign drive        = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign {a, b, c, d} = drive ? m_q : 4'h0;

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign table_out = table_q;
    assign mismatch  = mismatch_q;
    assign first_err = first_err_q;
    assign err_valid = err_valid_q;

endmodule
